// File: rtl/cl_dma_pcis_pkg.sv
// Shared definitions for the DMA PCIS register slice.
// Contents: bus width constants, packed per-channel payload types,
// the skid-buffer state encoding, and the handshake counter width.
package cl_dma_pcis_pkg;

    localparam int unsigned PCIS_ID_W   = 16;
    localparam int unsigned PCIS_ADDR_W = 64;
    localparam int unsigned PCIS_DATA_W = 512;
    localparam int unsigned PCIS_STRB_W = PCIS_DATA_W / 8;
    localparam int unsigned PCIS_LEN_W  = 8;
    localparam int unsigned PCIS_SIZE_W = 3;
    localparam int unsigned PCIS_RESP_W = 2;
    localparam int unsigned CNT_W       = 32;

    typedef struct packed {
        logic [PCIS_ID_W-1:0]   id;
        logic [PCIS_ADDR_W-1:0] addr;
        logic [PCIS_LEN_W-1:0]  len;
        logic [PCIS_SIZE_W-1:0] size;
    } aw_pl_t;

    typedef struct packed {
        logic [PCIS_DATA_W-1:0] data;
        logic [PCIS_STRB_W-1:0] strb;
        logic                   last;
    } w_pl_t;

    typedef struct packed {
        logic [PCIS_ID_W-1:0]   id;
        logic [PCIS_RESP_W-1:0] resp;
    } b_pl_t;

    typedef struct packed {
        logic [PCIS_ID_W-1:0]   id;
        logic [PCIS_ADDR_W-1:0] addr;
        logic [PCIS_LEN_W-1:0]  len;
        logic [PCIS_SIZE_W-1:0] size;
    } ar_pl_t;

    typedef struct packed {
        logic [PCIS_ID_W-1:0]   id;
        logic [PCIS_DATA_W-1:0] data;
        logic [PCIS_RESP_W-1:0] resp;
        logic                   last;
    } r_pl_t;

    // Encoding chosen so bit0 = main valid, bit1 = skid valid.
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_ONE   = 2'b01,
        SKID_FULL  = 2'b11
    } skid_state_t;

endpackage

// File: rtl/cl_axi_skid.sv
// Two-entry, fully registered valid/ready skid buffer for one AXI channel.
// Ports:
//   aclk, aresetn            clock, asynchronous active-low reset
//   s_valid/s_ready/s_data   upstream side (s_ready is purely registered)
//   m_valid/m_ready/m_data   downstream side (registered outputs)
// One cycle of latency, one beat per cycle sustained, at most two beats held.
module cl_axi_skid
    import cl_dma_pcis_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data
);

    skid_state_t  state, state_nxt;
    logic         rdy_q;
    logic         sk_valid;
    logic [W-1:0] m_data_q;
    logic [W-1:0] sk_data;
    logic         s_hs, m_hs;
    logic         load_main, load_skid, main_from_skid;

    assign m_valid  = (state != SKID_EMPTY);
    assign sk_valid = (state == SKID_FULL);
    // rdy_q holds readiness low for the first cycle out of reset.
    assign s_ready  = rdy_q & ~sk_valid;
    assign m_data   = m_data_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= SKID_EMPTY;
            rdy_q <= 1'b0;
        end else begin
            state <= state_nxt;
            rdy_q <= 1'b1;
        end
    end

    always_comb begin
        state_nxt      = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        s_hs           = s_valid & s_ready;
        m_hs           = m_valid & m_ready;
        case (state)
            SKID_EMPTY: begin
                if (s_hs) begin
                    state_nxt = SKID_ONE;
                    load_main = 1'b1;
                end
            end
            SKID_ONE: begin
                if (s_hs && m_hs) begin
                    load_main = 1'b1;
                end else if (s_hs) begin
                    state_nxt = SKID_FULL;
                    load_skid = 1'b1;
                end else if (m_hs) begin
                    state_nxt = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                // s_ready is low here, so only the drain can happen.
                if (m_hs) begin
                    state_nxt      = SKID_ONE;
                    main_from_skid = 1'b1;
                end
            end
            default: state_nxt = SKID_EMPTY;
        endcase
    end

    // Payload storage is intentionally not reset.
    always_ff @(posedge aclk) begin
        if (load_main) begin
            m_data_q <= s_data;
        end else if (main_from_skid) begin
            m_data_q <= sk_data;
        end
        if (load_skid) begin
            sk_data <= s_data;
        end
    end

endmodule

// File: rtl/cl_dma_pcis_slice.sv
// Full AXI4 register slice on the shell-to-CL DMA PCIS bus.
// sh_cl_dma_pcis_*   : bus from the shell (this block is the slave).
// sh_cl_dma_pcis_q_* : registered copy toward CL logic (this block is master).
// Channels AW, W, AR flow shell->CL; B, R flow CL->shell. Each passes
// through its own cl_axi_skid instance.
// aw_hs_cnt / ar_hs_cnt : AW / AR handshake counts on the _q side, live only
// when CL_DMA_PCIS_SLICE_CNT_EN is defined, otherwise constant 0.
module cl_dma_pcis_slice
    import cl_dma_pcis_pkg::*;
#(
    parameter int unsigned ID_W   = PCIS_ID_W,
    parameter int unsigned ADDR_W = PCIS_ADDR_W,
    parameter int unsigned DATA_W = PCIS_DATA_W,
    parameter int unsigned LEN_W  = PCIS_LEN_W
) (
    input  logic                aclk,
    input  logic                aresetn,

    input  logic [ID_W-1:0]     sh_cl_dma_pcis_awid,
    input  logic [ADDR_W-1:0]   sh_cl_dma_pcis_awaddr,
    input  logic [LEN_W-1:0]    sh_cl_dma_pcis_awlen,
    input  logic [2:0]          sh_cl_dma_pcis_awsize,
    input  logic                sh_cl_dma_pcis_awvalid,
    output logic                sh_cl_dma_pcis_awready,
    input  logic [DATA_W-1:0]   sh_cl_dma_pcis_wdata,
    input  logic [DATA_W/8-1:0] sh_cl_dma_pcis_wstrb,
    input  logic                sh_cl_dma_pcis_wlast,
    input  logic                sh_cl_dma_pcis_wvalid,
    output logic                sh_cl_dma_pcis_wready,
    output logic [ID_W-1:0]     sh_cl_dma_pcis_bid,
    output logic [1:0]          sh_cl_dma_pcis_bresp,
    output logic                sh_cl_dma_pcis_bvalid,
    input  logic                sh_cl_dma_pcis_bready,
    input  logic [ID_W-1:0]     sh_cl_dma_pcis_arid,
    input  logic [ADDR_W-1:0]   sh_cl_dma_pcis_araddr,
    input  logic [LEN_W-1:0]    sh_cl_dma_pcis_arlen,
    input  logic [2:0]          sh_cl_dma_pcis_arsize,
    input  logic                sh_cl_dma_pcis_arvalid,
    output logic                sh_cl_dma_pcis_arready,
    output logic [ID_W-1:0]     sh_cl_dma_pcis_rid,
    output logic [DATA_W-1:0]   sh_cl_dma_pcis_rdata,
    output logic [1:0]          sh_cl_dma_pcis_rresp,
    output logic                sh_cl_dma_pcis_rlast,
    output logic                sh_cl_dma_pcis_rvalid,
    input  logic                sh_cl_dma_pcis_rready,

    output logic [ID_W-1:0]     sh_cl_dma_pcis_q_awid,
    output logic [ADDR_W-1:0]   sh_cl_dma_pcis_q_awaddr,
    output logic [LEN_W-1:0]    sh_cl_dma_pcis_q_awlen,
    output logic [2:0]          sh_cl_dma_pcis_q_awsize,
    output logic                sh_cl_dma_pcis_q_awvalid,
    input  logic                sh_cl_dma_pcis_q_awready,
    output logic [DATA_W-1:0]   sh_cl_dma_pcis_q_wdata,
    output logic [DATA_W/8-1:0] sh_cl_dma_pcis_q_wstrb,
    output logic                sh_cl_dma_pcis_q_wlast,
    output logic                sh_cl_dma_pcis_q_wvalid,
    input  logic                sh_cl_dma_pcis_q_wready,
    input  logic [ID_W-1:0]     sh_cl_dma_pcis_q_bid,
    input  logic [1:0]          sh_cl_dma_pcis_q_bresp,
    input  logic                sh_cl_dma_pcis_q_bvalid,
    output logic                sh_cl_dma_pcis_q_bready,
    output logic [ID_W-1:0]     sh_cl_dma_pcis_q_arid,
    output logic [ADDR_W-1:0]   sh_cl_dma_pcis_q_araddr,
    output logic [LEN_W-1:0]    sh_cl_dma_pcis_q_arlen,
    output logic [2:0]          sh_cl_dma_pcis_q_arsize,
    output logic                sh_cl_dma_pcis_q_arvalid,
    input  logic                sh_cl_dma_pcis_q_arready,
    input  logic [ID_W-1:0]     sh_cl_dma_pcis_q_rid,
    input  logic [DATA_W-1:0]   sh_cl_dma_pcis_q_rdata,
    input  logic [1:0]          sh_cl_dma_pcis_q_rresp,
    input  logic                sh_cl_dma_pcis_q_rlast,
    input  logic                sh_cl_dma_pcis_q_rvalid,
    output logic                sh_cl_dma_pcis_q_rready,

    output logic [CNT_W-1:0]    aw_hs_cnt,
    output logic [CNT_W-1:0]    ar_hs_cnt
);

    aw_pl_t aw_in, aw_out;
    w_pl_t  w_in,  w_out;
    b_pl_t  b_in,  b_out;
    ar_pl_t ar_in, ar_out;
    r_pl_t  r_in,  r_out;

    // ---------------- forward: AW ----------------
    assign aw_in = '{id:   sh_cl_dma_pcis_awid,
                     addr: sh_cl_dma_pcis_awaddr,
                     len:  sh_cl_dma_pcis_awlen,
                     size: sh_cl_dma_pcis_awsize};

    cl_axi_skid #(.W($bits(aw_pl_t))) u_aw (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s_valid (sh_cl_dma_pcis_awvalid),
        .s_ready (sh_cl_dma_pcis_awready),
        .s_data  (aw_in),
        .m_valid (sh_cl_dma_pcis_q_awvalid),
        .m_ready (sh_cl_dma_pcis_q_awready),
        .m_data  (aw_out)
    );

    assign sh_cl_dma_pcis_q_awid   = aw_out.id;
    assign sh_cl_dma_pcis_q_awaddr = aw_out.addr;
    assign sh_cl_dma_pcis_q_awlen  = aw_out.len;
    assign sh_cl_dma_pcis_q_awsize = aw_out.size;

    // ---------------- forward: W ----------------
    assign w_in = '{data: sh_cl_dma_pcis_wdata,
                    strb: sh_cl_dma_pcis_wstrb,
                    last: sh_cl_dma_pcis_wlast};

    cl_axi_skid #(.W($bits(w_pl_t))) u_w (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s_valid (sh_cl_dma_pcis_wvalid),
        .s_ready (sh_cl_dma_pcis_wready),
        .s_data  (w_in),
        .m_valid (sh_cl_dma_pcis_q_wvalid),
        .m_ready (sh_cl_dma_pcis_q_wready),
        .m_data  (w_out)
    );

    assign sh_cl_dma_pcis_q_wdata = w_out.data;
    assign sh_cl_dma_pcis_q_wstrb = w_out.strb;
    assign sh_cl_dma_pcis_q_wlast = w_out.last;

    // ---------------- reverse: B ----------------
    assign b_in = '{id:   sh_cl_dma_pcis_q_bid,
                    resp: sh_cl_dma_pcis_q_bresp};

    cl_axi_skid #(.W($bits(b_pl_t))) u_b (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s_valid (sh_cl_dma_pcis_q_bvalid),
        .s_ready (sh_cl_dma_pcis_q_bready),
        .s_data  (b_in),
        .m_valid (sh_cl_dma_pcis_bvalid),
        .m_ready (sh_cl_dma_pcis_bready),
        .m_data  (b_out)
    );

    assign sh_cl_dma_pcis_bid   = b_out.id;
    assign sh_cl_dma_pcis_bresp = b_out.resp;

    // ---------------- forward: AR ----------------
    assign ar_in = '{id:   sh_cl_dma_pcis_arid,
                     addr: sh_cl_dma_pcis_araddr,
                     len:  sh_cl_dma_pcis_arlen,
                     size: sh_cl_dma_pcis_arsize};

    cl_axi_skid #(.W($bits(ar_pl_t))) u_ar (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s_valid (sh_cl_dma_pcis_arvalid),
        .s_ready (sh_cl_dma_pcis_arready),
        .s_data  (ar_in),
        .m_valid (sh_cl_dma_pcis_q_arvalid),
        .m_ready (sh_cl_dma_pcis_q_arready),
        .m_data  (ar_out)
    );

    assign sh_cl_dma_pcis_q_arid   = ar_out.id;
    assign sh_cl_dma_pcis_q_araddr = ar_out.addr;
    assign sh_cl_dma_pcis_q_arlen  = ar_out.len;
    assign sh_cl_dma_pcis_q_arsize = ar_out.size;

    // ---------------- reverse: R ----------------
    assign r_in = '{id:   sh_cl_dma_pcis_q_rid,
                    data: sh_cl_dma_pcis_q_rdata,
                    resp: sh_cl_dma_pcis_q_rresp,
                    last: sh_cl_dma_pcis_q_rlast};

    cl_axi_skid #(.W($bits(r_pl_t))) u_r (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s_valid (sh_cl_dma_pcis_q_rvalid),
        .s_ready (sh_cl_dma_pcis_q_rready),
        .s_data  (r_in),
        .m_valid (sh_cl_dma_pcis_rvalid),
        .m_ready (sh_cl_dma_pcis_rready),
        .m_data  (r_out)
    );

    assign sh_cl_dma_pcis_rid   = r_out.id;
    assign sh_cl_dma_pcis_rdata = r_out.data;
    assign sh_cl_dma_pcis_rresp = r_out.resp;
    assign sh_cl_dma_pcis_rlast = r_out.last;

    // ---------------- bring-up counters ----------------
`ifdef CL_DMA_PCIS_SLICE_CNT_EN
    logic [CNT_W-1:0] aw_cnt;
    logic [CNT_W-1:0] ar_cnt;

    // Free-running and wrapping; overflow is expected on long runs.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_cnt <= '0;
            ar_cnt <= '0;
        end else begin
            if (sh_cl_dma_pcis_q_awvalid && sh_cl_dma_pcis_q_awready) begin
                aw_cnt <= aw_cnt + 1'b1;
            end
            if (sh_cl_dma_pcis_q_arvalid && sh_cl_dma_pcis_q_arready) begin
                ar_cnt <= ar_cnt + 1'b1;
            end
        end
    end

    assign aw_hs_cnt = aw_cnt;
    assign ar_hs_cnt = ar_cnt;
`else
    assign aw_hs_cnt = '0;
    assign ar_hs_cnt = '0;
`endif

endmodule

// File: tb/tb_cl_dma_pcis_slice.sv
module tb_cl_dma_pcis_slice;
    logic          aclk;
    logic          aresetn;

    logic [15:0]   sh_cl_dma_pcis_awid;
    logic [63:0]   sh_cl_dma_pcis_awaddr;
    logic [7:0]    sh_cl_dma_pcis_awlen;
    logic [2:0]    sh_cl_dma_pcis_awsize;
    logic          sh_cl_dma_pcis_awvalid, sh_cl_dma_pcis_awready;
    logic [511:0]  sh_cl_dma_pcis_wdata;
    logic [63:0]   sh_cl_dma_pcis_wstrb;
    logic          sh_cl_dma_pcis_wlast, sh_cl_dma_pcis_wvalid, sh_cl_dma_pcis_wready;
    logic [15:0]   sh_cl_dma_pcis_bid;
    logic [1:0]    sh_cl_dma_pcis_bresp;
    logic          sh_cl_dma_pcis_bvalid, sh_cl_dma_pcis_bready;
    logic [15:0]   sh_cl_dma_pcis_arid;
    logic [63:0]   sh_cl_dma_pcis_araddr;
    logic [7:0]    sh_cl_dma_pcis_arlen;
    logic [2:0]    sh_cl_dma_pcis_arsize;
    logic          sh_cl_dma_pcis_arvalid, sh_cl_dma_pcis_arready;
    logic [15:0]   sh_cl_dma_pcis_rid;
    logic [511:0]  sh_cl_dma_pcis_rdata;
    logic [1:0]    sh_cl_dma_pcis_rresp;
    logic          sh_cl_dma_pcis_rlast, sh_cl_dma_pcis_rvalid, sh_cl_dma_pcis_rready;

    logic [15:0]   sh_cl_dma_pcis_q_awid;
    logic [63:0]   sh_cl_dma_pcis_q_awaddr;
    logic [7:0]    sh_cl_dma_pcis_q_awlen;
    logic [2:0]    sh_cl_dma_pcis_q_awsize;
    logic          sh_cl_dma_pcis_q_awvalid, sh_cl_dma_pcis_q_awready;
    logic [511:0]  sh_cl_dma_pcis_q_wdata;
    logic [63:0]   sh_cl_dma_pcis_q_wstrb;
    logic          sh_cl_dma_pcis_q_wlast, sh_cl_dma_pcis_q_wvalid, sh_cl_dma_pcis_q_wready;
    logic [15:0]   sh_cl_dma_pcis_q_bid;
    logic [1:0]    sh_cl_dma_pcis_q_bresp;
    logic          sh_cl_dma_pcis_q_bvalid, sh_cl_dma_pcis_q_bready;
    logic [15:0]   sh_cl_dma_pcis_q_arid;
    logic [63:0]   sh_cl_dma_pcis_q_araddr;
    logic [7:0]    sh_cl_dma_pcis_q_arlen;
    logic [2:0]    sh_cl_dma_pcis_q_arsize;
    logic          sh_cl_dma_pcis_q_arvalid, sh_cl_dma_pcis_q_arready;
    logic [15:0]   sh_cl_dma_pcis_q_rid;
    logic [511:0]  sh_cl_dma_pcis_q_rdata;
    logic [1:0]    sh_cl_dma_pcis_q_rresp;
    logic          sh_cl_dma_pcis_q_rlast, sh_cl_dma_pcis_q_rvalid, sh_cl_dma_pcis_q_rready;

    logic [31:0]   aw_hs_cnt, ar_hs_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    cl_dma_pcis_slice dut (
        .aclk                     (aclk),
        .aresetn                  (aresetn),
        .sh_cl_dma_pcis_awid      (sh_cl_dma_pcis_awid),
        .sh_cl_dma_pcis_awaddr    (sh_cl_dma_pcis_awaddr),
        .sh_cl_dma_pcis_awlen     (sh_cl_dma_pcis_awlen),
        .sh_cl_dma_pcis_awsize    (sh_cl_dma_pcis_awsize),
        .sh_cl_dma_pcis_awvalid   (sh_cl_dma_pcis_awvalid),
        .sh_cl_dma_pcis_awready   (sh_cl_dma_pcis_awready),
        .sh_cl_dma_pcis_wdata     (sh_cl_dma_pcis_wdata),
        .sh_cl_dma_pcis_wstrb     (sh_cl_dma_pcis_wstrb),
        .sh_cl_dma_pcis_wlast     (sh_cl_dma_pcis_wlast),
        .sh_cl_dma_pcis_wvalid    (sh_cl_dma_pcis_wvalid),
        .sh_cl_dma_pcis_wready    (sh_cl_dma_pcis_wready),
        .sh_cl_dma_pcis_bid       (sh_cl_dma_pcis_bid),
        .sh_cl_dma_pcis_bresp     (sh_cl_dma_pcis_bresp),
        .sh_cl_dma_pcis_bvalid    (sh_cl_dma_pcis_bvalid),
        .sh_cl_dma_pcis_bready    (sh_cl_dma_pcis_bready),
        .sh_cl_dma_pcis_arid      (sh_cl_dma_pcis_arid),
        .sh_cl_dma_pcis_araddr    (sh_cl_dma_pcis_araddr),
        .sh_cl_dma_pcis_arlen     (sh_cl_dma_pcis_arlen),
        .sh_cl_dma_pcis_arsize    (sh_cl_dma_pcis_arsize),
        .sh_cl_dma_pcis_arvalid   (sh_cl_dma_pcis_arvalid),
        .sh_cl_dma_pcis_arready   (sh_cl_dma_pcis_arready),
        .sh_cl_dma_pcis_rid       (sh_cl_dma_pcis_rid),
        .sh_cl_dma_pcis_rdata     (sh_cl_dma_pcis_rdata),
        .sh_cl_dma_pcis_rresp     (sh_cl_dma_pcis_rresp),
        .sh_cl_dma_pcis_rlast     (sh_cl_dma_pcis_rlast),
        .sh_cl_dma_pcis_rvalid    (sh_cl_dma_pcis_rvalid),
        .sh_cl_dma_pcis_rready    (sh_cl_dma_pcis_rready),
        .sh_cl_dma_pcis_q_awid    (sh_cl_dma_pcis_q_awid),
        .sh_cl_dma_pcis_q_awaddr  (sh_cl_dma_pcis_q_awaddr),
        .sh_cl_dma_pcis_q_awlen   (sh_cl_dma_pcis_q_awlen),
        .sh_cl_dma_pcis_q_awsize  (sh_cl_dma_pcis_q_awsize),
        .sh_cl_dma_pcis_q_awvalid (sh_cl_dma_pcis_q_awvalid),
        .sh_cl_dma_pcis_q_awready (sh_cl_dma_pcis_q_awready),
        .sh_cl_dma_pcis_q_wdata   (sh_cl_dma_pcis_q_wdata),
        .sh_cl_dma_pcis_q_wstrb   (sh_cl_dma_pcis_q_wstrb),
        .sh_cl_dma_pcis_q_wlast   (sh_cl_dma_pcis_q_wlast),
        .sh_cl_dma_pcis_q_wvalid  (sh_cl_dma_pcis_q_wvalid),
        .sh_cl_dma_pcis_q_wready  (sh_cl_dma_pcis_q_wready),
        .sh_cl_dma_pcis_q_bid     (sh_cl_dma_pcis_q_bid),
        .sh_cl_dma_pcis_q_bresp   (sh_cl_dma_pcis_q_bresp),
        .sh_cl_dma_pcis_q_bvalid  (sh_cl_dma_pcis_q_bvalid),
        .sh_cl_dma_pcis_q_bready  (sh_cl_dma_pcis_q_bready),
        .sh_cl_dma_pcis_q_arid    (sh_cl_dma_pcis_q_arid),
        .sh_cl_dma_pcis_q_araddr  (sh_cl_dma_pcis_q_araddr),
        .sh_cl_dma_pcis_q_arlen   (sh_cl_dma_pcis_q_arlen),
        .sh_cl_dma_pcis_q_arsize  (sh_cl_dma_pcis_q_arsize),
        .sh_cl_dma_pcis_q_arvalid (sh_cl_dma_pcis_q_arvalid),
        .sh_cl_dma_pcis_q_arready (sh_cl_dma_pcis_q_arready),
        .sh_cl_dma_pcis_q_rid     (sh_cl_dma_pcis_q_rid),
        .sh_cl_dma_pcis_q_rdata   (sh_cl_dma_pcis_q_rdata),
        .sh_cl_dma_pcis_q_rresp   (sh_cl_dma_pcis_q_rresp),
        .sh_cl_dma_pcis_q_rlast   (sh_cl_dma_pcis_q_rlast),
        .sh_cl_dma_pcis_q_rvalid  (sh_cl_dma_pcis_q_rvalid),
        .sh_cl_dma_pcis_q_rready  (sh_cl_dma_pcis_q_rready),
        .aw_hs_cnt                (aw_hs_cnt),
        .ar_hs_cnt                (ar_hs_cnt)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [511:0] beat_data(input int unsigned k);
        logic [511:0] d;
        for (int unsigned j = 0; j < 16; j++) d[j*32 +: 32] = k * 32'h0101_0101 + j;
        return d;
    endfunction

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    initial begin : stim
        int tx, rx, nval, first, last, order_err;
        logic hs_in, hs_out;
        logic [31:0] exp_aw, exp_ar;

        aresetn = 1'b0;
        sh_cl_dma_pcis_awid = '0; sh_cl_dma_pcis_awaddr = '0; sh_cl_dma_pcis_awlen = '0;
        sh_cl_dma_pcis_awsize = '0; sh_cl_dma_pcis_awvalid = 1'b0;
        sh_cl_dma_pcis_wdata = '0; sh_cl_dma_pcis_wstrb = '0; sh_cl_dma_pcis_wlast = 1'b0;
        sh_cl_dma_pcis_wvalid = 1'b0; sh_cl_dma_pcis_bready = 1'b0;
        sh_cl_dma_pcis_arid = '0; sh_cl_dma_pcis_araddr = '0; sh_cl_dma_pcis_arlen = '0;
        sh_cl_dma_pcis_arsize = '0; sh_cl_dma_pcis_arvalid = 1'b0; sh_cl_dma_pcis_rready = 1'b0;
        sh_cl_dma_pcis_q_awready = 1'b0; sh_cl_dma_pcis_q_wready = 1'b0; sh_cl_dma_pcis_q_arready = 1'b0;
        sh_cl_dma_pcis_q_bid = '0; sh_cl_dma_pcis_q_bresp = '0; sh_cl_dma_pcis_q_bvalid = 1'b0;
        sh_cl_dma_pcis_q_rid = '0; sh_cl_dma_pcis_q_rdata = '0; sh_cl_dma_pcis_q_rresp = '0;
        sh_cl_dma_pcis_q_rlast = 1'b0; sh_cl_dma_pcis_q_rvalid = 1'b0;

        // ---- reset release ----
        repeat (5) tick();
        check("rst_q_awvalid", sh_cl_dma_pcis_q_awvalid, 0);
        check("rst_q_wvalid",  sh_cl_dma_pcis_q_wvalid, 0);
        check("rst_q_arvalid", sh_cl_dma_pcis_q_arvalid, 0);
        check("rst_bvalid",    sh_cl_dma_pcis_bvalid, 0);
        check("rst_rvalid",    sh_cl_dma_pcis_rvalid, 0);
        check("rst_awready",   sh_cl_dma_pcis_awready, 0);
        check("rst_wready",    sh_cl_dma_pcis_wready, 0);
        check("rst_arready",   sh_cl_dma_pcis_arready, 0);
        check("rst_q_bready",  sh_cl_dma_pcis_q_bready, 0);
        check("rst_q_rready",  sh_cl_dma_pcis_q_rready, 0);
        check("rst_aw_cnt",    aw_hs_cnt, 0);
        check("rst_ar_cnt",    ar_hs_cnt, 0);
        aresetn = 1'b1;
        check("awready_pre_edge", sh_cl_dma_pcis_awready, 0);
        tick();
        check("awready_1cyc",  sh_cl_dma_pcis_awready, 1);
        check("wready_1cyc",   sh_cl_dma_pcis_wready, 1);
        check("arready_1cyc",  sh_cl_dma_pcis_arready, 1);
        check("q_bready_1cyc", sh_cl_dma_pcis_q_bready, 1);
        check("q_rready_1cyc", sh_cl_dma_pcis_q_rready, 1);

        // ---- single write ----
        sh_cl_dma_pcis_q_awready = 1'b1; sh_cl_dma_pcis_q_wready = 1'b1;
        sh_cl_dma_pcis_q_arready = 1'b1; sh_cl_dma_pcis_bready = 1'b1; sh_cl_dma_pcis_rready = 1'b1;
        sh_cl_dma_pcis_awid = 16'd3; sh_cl_dma_pcis_awaddr = 64'h1000;
        sh_cl_dma_pcis_awlen = 8'd3; sh_cl_dma_pcis_awsize = 3'd6; sh_cl_dma_pcis_awvalid = 1'b1;
        tick();
        sh_cl_dma_pcis_awvalid = 1'b0;
        check("aw_q_valid", sh_cl_dma_pcis_q_awvalid, 1);
        check("aw_q_id",    sh_cl_dma_pcis_q_awid, 3);
        check("aw_q_addr",  sh_cl_dma_pcis_q_awaddr, 64'h1000);
        check("aw_q_len",   sh_cl_dma_pcis_q_awlen, 3);
        check("aw_q_size",  sh_cl_dma_pcis_q_awsize, 6);
        for (int i = 0; i < 4; i++) begin
            sh_cl_dma_pcis_wvalid = 1'b1;
            sh_cl_dma_pcis_wdata  = beat_data(16 + i);
            sh_cl_dma_pcis_wstrb  = '1;
            sh_cl_dma_pcis_wlast  = (i == 3);
            tick();
            if (i == 0) check("aw_q_drained", sh_cl_dma_pcis_q_awvalid, 0);
            check("w_q_valid", sh_cl_dma_pcis_q_wvalid, 1);
            check("w_q_data",  sh_cl_dma_pcis_q_wdata, beat_data(16 + i));
            check("w_q_strb",  sh_cl_dma_pcis_q_wstrb, 64'hFFFF_FFFF_FFFF_FFFF);
            check("w_q_last",  sh_cl_dma_pcis_q_wlast, (i == 3));
        end
        sh_cl_dma_pcis_wvalid = 1'b0; sh_cl_dma_pcis_wlast = 1'b0;
        tick();
        check("w_q_idle", sh_cl_dma_pcis_q_wvalid, 0);
        sh_cl_dma_pcis_q_bvalid = 1'b1; sh_cl_dma_pcis_q_bid = 16'd3; sh_cl_dma_pcis_q_bresp = 2'd0;
        tick();
        sh_cl_dma_pcis_q_bvalid = 1'b0;
        check("b_valid", sh_cl_dma_pcis_bvalid, 1);
        check("b_id",    sh_cl_dma_pcis_bid, 3);
        check("b_resp",  sh_cl_dma_pcis_bresp, 0);
        tick();
        check("b_idle",  sh_cl_dma_pcis_bvalid, 0);

        // ---- R backpressure: downstream ready low in cycles 3..7 ----
        tx = 0; rx = 0;
        for (int c = 0; c < 60 && rx < 16; c++) begin
            sh_cl_dma_pcis_rready   = !(c >= 3 && c <= 7);
            sh_cl_dma_pcis_q_rvalid = (tx < 16);
            sh_cl_dma_pcis_q_rid    = 16'(tx);
            sh_cl_dma_pcis_q_rdata  = beat_data(32'hA00 + tx);
            sh_cl_dma_pcis_q_rresp  = 2'd0;
            sh_cl_dma_pcis_q_rlast  = (tx == 15);
            if (c == 3) check("bp_q_rready_c3", sh_cl_dma_pcis_q_rready, 1);
            if (c == 4) check("bp_q_rready_c4", sh_cl_dma_pcis_q_rready, 0);
            if (c == 8) check("bp_q_rready_c8", sh_cl_dma_pcis_q_rready, 0);
            if (c == 9) check("bp_q_rready_c9", sh_cl_dma_pcis_q_rready, 1);
            if (c == 6) begin
                check("bp_held_valid", sh_cl_dma_pcis_rvalid, 1);
                check("bp_held_data",  sh_cl_dma_pcis_rdata, beat_data(32'hA02));
            end
            hs_in  = sh_cl_dma_pcis_q_rvalid && sh_cl_dma_pcis_q_rready;
            hs_out = sh_cl_dma_pcis_rvalid && sh_cl_dma_pcis_rready;
            if (hs_out) begin
                check("bp_rdata", sh_cl_dma_pcis_rdata, beat_data(32'hA00 + rx));
                check("bp_rid",   sh_cl_dma_pcis_rid, rx);
                check("bp_rlast", sh_cl_dma_pcis_rlast, (rx == 15));
                rx++;
            end
            tick();
            if (hs_in) tx++;
        end
        sh_cl_dma_pcis_q_rvalid = 1'b0; sh_cl_dma_pcis_rready = 1'b1;
        check("bp_rx_count", rx, 16);
        check("bp_tx_count", tx, 16);
        check("bp_drained",  sh_cl_dma_pcis_rvalid, 0);

        // ---- full throughput: AR len=255 then 256 R beats ----
        sh_cl_dma_pcis_arid = 16'h55; sh_cl_dma_pcis_araddr = 64'h2000;
        sh_cl_dma_pcis_arlen = 8'd255; sh_cl_dma_pcis_arsize = 3'd6; sh_cl_dma_pcis_arvalid = 1'b1;
        tick();
        sh_cl_dma_pcis_arvalid = 1'b0;
        check("ar_q_valid", sh_cl_dma_pcis_q_arvalid, 1);
        check("ar_q_id",    sh_cl_dma_pcis_q_arid, 16'h55);
        check("ar_q_addr",  sh_cl_dma_pcis_q_araddr, 64'h2000);
        check("ar_q_len",   sh_cl_dma_pcis_q_arlen, 255);
        tx = 0; rx = 0; nval = 0; first = -1; last = -1; order_err = 0;
        for (int c = 0; c < 300 && rx < 256; c++) begin
            sh_cl_dma_pcis_q_rvalid = (tx < 256);
            sh_cl_dma_pcis_q_rid    = 16'h55;
            sh_cl_dma_pcis_q_rdata  = beat_data(32'h100 + tx);
            sh_cl_dma_pcis_q_rlast  = (tx == 255);
            hs_in = sh_cl_dma_pcis_q_rvalid && sh_cl_dma_pcis_q_rready;
            if (sh_cl_dma_pcis_rvalid) begin
                if (first < 0) first = c;
                last = c;
                nval++;
                if (sh_cl_dma_pcis_rdata !== beat_data(32'h100 + rx)) order_err++;
                rx++;
            end
            tick();
            if (hs_in) tx++;
        end
        sh_cl_dma_pcis_q_rvalid = 1'b0;
        check("tp_valid_cycles", nval, 256);
        check("tp_no_bubbles",   last - first + 1, 256);
        check("tp_order_errors", order_err, 0);

        // ---- reset during beat 5 of a 16-beat W burst ----
        for (int i = 0; i < 16; i++) begin
            sh_cl_dma_pcis_wvalid = 1'b1;
            sh_cl_dma_pcis_wdata  = beat_data(32'h300 + i);
            sh_cl_dma_pcis_wlast  = (i == 15);
            if (i == 4) begin
                check("mid_pre_wvalid", sh_cl_dma_pcis_q_wvalid, 1);
                #1 aresetn = 1'b0;
                #1;
                check("mid_q_wvalid",  sh_cl_dma_pcis_q_wvalid, 0);
                check("mid_q_awvalid", sh_cl_dma_pcis_q_awvalid, 0);
                check("mid_q_arvalid", sh_cl_dma_pcis_q_arvalid, 0);
                check("mid_bvalid",    sh_cl_dma_pcis_bvalid, 0);
                check("mid_rvalid",    sh_cl_dma_pcis_rvalid, 0);
                check("mid_wready",    sh_cl_dma_pcis_wready, 0);
                break;
            end
            tick();
        end
        sh_cl_dma_pcis_wvalid = 1'b0; sh_cl_dma_pcis_wlast = 1'b0;
        repeat (2) tick();
        aresetn = 1'b1;
        tick();
        check("rec_wready",   sh_cl_dma_pcis_wready, 1);
        check("rec_q_wvalid", sh_cl_dma_pcis_q_wvalid, 0);
        for (int i = 0; i < 2; i++) begin
            sh_cl_dma_pcis_wvalid = 1'b1;
            sh_cl_dma_pcis_wdata  = beat_data(32'h400 + i);
            sh_cl_dma_pcis_wlast  = (i == 1);
            tick();
            check("rec_w_data", sh_cl_dma_pcis_q_wdata, beat_data(32'h400 + i));
            check("rec_w_last", sh_cl_dma_pcis_q_wlast, (i == 1));
        end
        sh_cl_dma_pcis_wvalid = 1'b0; sh_cl_dma_pcis_wlast = 1'b0;
        tick();

        // ---- handshake counters ----
`ifdef CL_DMA_PCIS_SLICE_CNT_EN
        force dut.aw_cnt = 32'hFFFF_FFFE;
        tick();
        release dut.aw_cnt;
        exp_aw = 32'h0000_0001;
        exp_ar = 32'h0000_0001;
`else
        exp_aw = 32'h0;
        exp_ar = 32'h0;
`endif
        for (int i = 0; i < 3; i++) begin
            sh_cl_dma_pcis_awvalid = 1'b1;
            sh_cl_dma_pcis_awid    = 16'(7 + i);
            tick();
        end
        sh_cl_dma_pcis_awvalid = 1'b0;
        sh_cl_dma_pcis_arvalid = 1'b1;
        tick();
        sh_cl_dma_pcis_arvalid = 1'b0;
        repeat (3) tick();
        check("cnt_aw", aw_hs_cnt, exp_aw);
        check("cnt_ar", ar_hs_cnt, exp_ar);
        check("cnt_q_awvalid_idle", sh_cl_dma_pcis_q_awvalid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
